md_sched: RTL and testbench

MD_SCHED -- requirements
Module: md_sched

---
 rtl/md_sched_if.sv | 44 ++++
 rtl/md_sched.sv | 164 ++++++++++++++++
 tb/tb_md_sched.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_sched_if.sv
// md_sched_if: E/M-stage request, cancel and HI/LO result signals of the mult/div scheduler.
// The master modport drives the pipeline side; the slave modport is the scheduler itself.

interface md_sched_if;
    logic        startE;
    logic [2:0]  md_opE;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        flushE;
    logic        cancelM;
    logic        md_useD;
    logic        busy;
    logic        stallD;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output startE,
        output md_opE,
        output srcA,
        output srcB,
        output flushE,
        output cancelM,
        output md_useD,
        input  busy,
        input  stallD,
        input  hi,
        input  lo
    );

    modport slave (
        input  startE,
        input  md_opE,
        input  srcA,
        input  srcB,
        input  flushE,
        input  cancelM,
        input  md_useD,
        output busy,
        output stallD,
        output hi,
        output lo
    );
endinterface

// File: rtl/md_sched.sv
// md_sched: HI/LO scheduler; mult/multu hold busy 5 cycles, mthi/mtlo write at once.
// Define MD_SCHED_DIV_EN to add div/divu (10-cycle busy); otherwise opcodes 3/4 are no-ops.

module md_sched (
    input logic       clk,
    input logic       rst_n,
    md_sched_if.slave bus
);
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] BUSY     = 1'b1;
    localparam logic [3:0] MULT_CNT = 4'd4;
    localparam logic [3:0] DIV_CNT  = 4'd9;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        first_q, first_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic op_mult, op_div, op_mt, accept;

    assign op_mult = (bus.md_opE == OP_MULT) || (bus.md_opE == OP_MULTU);
    assign op_mt   = (bus.md_opE == OP_MTHI) || (bus.md_opE == OP_MTLO);
`ifdef MD_SCHED_DIV_EN
    assign op_div  = (bus.md_opE == OP_DIV) || (bus.md_opE == OP_DIVU);
`else
    assign op_div  = 1'b0;
`endif

    assign accept = bus.startE & ~bus.flushE & (state_q == IDLE) & (op_mult | op_div | op_mt);

    // Sign extension picks signed vs unsigned; the low 64 product bits are then the same.
    logic        mul_sgn;
    logic [63:0] mul_a, mul_b, mul_p;

    assign mul_sgn = (bus.md_opE == OP_MULT);
    assign mul_a   = {{32{mul_sgn & bus.srcA[31]}}, bus.srcA};
    assign mul_b   = {{32{mul_sgn & bus.srcB[31]}}, bus.srcB};
    assign mul_p   = mul_a * mul_b;

    logic [31:0] div_q, div_r;
    logic        div_wr;

`ifdef MD_SCHED_DIV_EN
    logic        div_sgn, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;

    // Divide magnitudes, then restore signs: quotient truncates, remainder follows dividend.
    assign div_sgn = (bus.md_opE == OP_DIV);
    assign a_neg   = div_sgn & bus.srcA[31];
    assign b_neg   = div_sgn & bus.srcB[31];
    assign a_mag   = a_neg ? (~bus.srcA + 32'd1) : bus.srcA;
    assign b_mag   = b_neg ? (~bus.srcB + 32'd1) : bus.srcB;
    assign b_safe  = (bus.srcB == 32'd0) ? 32'd1 : b_mag;
    assign q_mag   = a_mag / b_safe;
    assign r_mag   = a_mag % b_safe;
    assign div_q   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign div_r   = a_neg ? (~r_mag + 32'd1) : r_mag;
    assign div_wr  = (bus.srcB != 32'd0);
`else
    assign div_q   = 32'd0;
    assign div_r   = 32'd0;
    assign div_wr  = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op_mt) begin
                        if (bus.md_opE == OP_MTHI) begin
                            hi_d = bus.srcA;
                        end else begin
                            lo_d = bus.srcA;
                        end
                    end else begin
                        state_d = BUSY;
                        first_d = 1'b1;
                        if (op_mult) begin
                            cnt_d     = MULT_CNT;
                            pend_hi_d = mul_p[63:32];
                            pend_lo_d = mul_p[31:0];
                            pend_wr_d = 1'b1;
                        end else begin
                            cnt_d     = DIV_CNT;
                            pend_hi_d = div_r;
                            pend_lo_d = div_q;
                            pend_wr_d = div_wr;
                        end
                    end
                end
            end
            BUSY: begin
                first_d = 1'b0;
                if (first_q && bus.cancelM) begin
                    // Starting instruction faulted in M: drop the result.
                    state_d   = IDLE;
                    cnt_d     = 4'd0;
                    pend_hi_d = 32'd0;
                    pend_lo_d = 32'd0;
                    pend_wr_d = 1'b0;
                end else if (cnt_q == 4'd0) begin
                    state_d   = IDLE;
                    pend_wr_d = 1'b0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            first_q   <= 1'b0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy   = (state_q == BUSY);
    assign bus.stallD = bus.md_useD & ((state_q == BUSY) | (bus.startE & (op_mult | op_div)));
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed vector table, hand sequences and random traffic for md_sched,
// every cycle compared against a transaction-level HI/LO model.

module tb_md_sched;
`ifdef MD_SCHED_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    md_sched_if bus ();

    md_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Model: remaining busy cycles and the result the operation will commit.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
    int          m_left = 0;
    int          m_age = 0;
    bit          m_wr = 1'b0;

    logic bs, ss;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        int          cyc;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit long_op(input logic [2:0] op);
        return (op == 3'd1) || (op == 3'd2) || (DIV_ON && ((op == 3'd3) || (op == 3'd4)));
    endfunction

    task automatic model_reset();
        m_hi = 32'd0;
        m_lo = 32'd0;
        m_left = 0;
        m_age = 0;
        m_wr = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic fl, input logic cn);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        if (m_left > 0) begin
            if (m_age == 0 && cn) begin
                m_left = 0;
            end else begin
                m_left--;
                m_age++;
                if (m_left == 0 && m_wr) begin
                    m_hi = m_phi;
                    m_lo = m_plo;
                end
            end
        end else if (st && !fl) begin
            if (op == 3'd5) m_hi = a;
            else if (op == 3'd6) m_lo = a;
            else if (long_op(op)) begin
                m_age = 0;
                if (op <= 3'd2) begin
                    p = (op == 3'd1) ? 64'(sa * sb) : 64'(ua * ub);
                    m_phi = p[63:32];
                    m_plo = p[31:0];
                    m_wr = 1'b1;
                    m_left = 5;
                end else begin
                    m_left = 10;
                    m_wr = (b != 32'd0);
                    if (b != 32'd0) begin
                        m_plo = (op == 3'd3) ? 32'(sa / sb) : 32'(ua / ub);
                        m_phi = (op == 3'd3) ? 32'(sa % sb) : 32'(ua % ub);
                    end
                end
            end
        end
    endtask

    // One clock: drive at negedge, compare against the model, take the edge, advance the model.
    task automatic cycle(input logic st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic fl, input logic cn, input logic ud,
                         output logic busy_s, output logic stall_s);
        logic exp_stall;
        @(negedge clk);
        bus.startE = st;
        bus.md_opE = op;
        bus.srcA = a;
        bus.srcB = b;
        bus.flushE = fl;
        bus.cancelM = cn;
        bus.md_useD = ud;
        #1;
        busy_s = bus.busy;
        stall_s = bus.stallD;
        exp_stall = ud & ((m_left > 0) | (st & long_op(op)));
        chk("model busy", bus.busy, 64'(m_left > 0));
        chk("model stallD", bus.stallD, 64'(exp_stall));
        chk("model hi", bus.hi, 64'(m_hi));
        chk("model lo", bus.lo, 64'(m_lo));
        @(posedge clk);
        model_edge(st, op, a, b, fl, cn);
        #1;
    endtask

    task automatic idle(output logic busy_s);
        logic s;
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, busy_s, s);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.startE = 1'b0;
        bus.md_opE = 3'd0;
        bus.flushE = 1'b0;
        bus.cancelM = 1'b0;
        bus.md_useD = 1'b0;
        #1;
        chk("reset busy", bus.busy, 64'd0);
        chk("reset hi", bus.hi, 64'd0);
        chk("reset lo", bus.lo, 64'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        logic b1, s1;
        cycle(1'b1, 3'd5, h, 32'd0, 1'b0, 1'b0, 1'b0, b1, s1);
        cycle(1'b1, 3'd6, l, 32'd0, 1'b0, 1'b0, 1'b0, b1, s1);
    endtask

    task automatic run_until_idle(output int n);
        logic b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            idle(b1);
            if (!b1) break;
            n++;
        end
    endtask

    function automatic vec_t mk(input string name, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] ph,
                                input logic [31:0] pl, input int cyc, input logic [31:0] eh,
                                input logic [31:0] el);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.pre_hi = ph; v.pre_lo = pl;
        v.cyc = cyc; v.exp_hi = eh; v.exp_lo = el;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n, n2;
        vt[0] = mk("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 32'h11111111, 32'h22222222,
                   5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        vt[1] = mk("multu", 3'd2, 32'hFFFFFFFE, 32'd3, 32'h11111111, 32'h22222222,
                   5, 32'h00000002, 32'hFFFFFFFA);
        vt[2] = mk("div -7/2", 3'd3, 32'hFFFFFFF9, 32'd2, 32'h11111111, 32'h22222222,
                   DIV_ON ? 10 : 0, DIV_ON ? 32'hFFFFFFFF : 32'h11111111,
                   DIV_ON ? 32'hFFFFFFFD : 32'h22222222);
        vt[3] = mk("divu by0", 3'd4, 32'h00000100, 32'd0, 32'hAAAA5555, 32'h5555AAAA,
                   DIV_ON ? 10 : 0, 32'hAAAA5555, 32'h5555AAAA);
        vt[4] = mk("div 100/-7", 3'd3, 32'd100, 32'hFFFFFFF9, 32'h0, 32'h0,
                   DIV_ON ? 10 : 0, DIV_ON ? 32'd2 : 32'd0, DIV_ON ? 32'hFFFFFFF2 : 32'd0);
        vt[5] = mk("divu big", 3'd4, 32'h80000000, 32'd3, 32'h0, 32'h0,
                   DIV_ON ? 10 : 0, DIV_ON ? 32'd2 : 32'd0, DIV_ON ? 32'h2AAAAAAA : 32'd0);
        vt[6] = mk("mtlo", 3'd6, 32'h12345678, 32'd0, 32'h33333333, 32'h44444444,
                   0, 32'h33333333, 32'h12345678);
        vt[7] = mk("mthi", 3'd5, 32'h9ABCDEF0, 32'd0, 32'h33333333, 32'h44444444,
                   0, 32'h9ABCDEF0, 32'h44444444);
        vt[8] = mk("nop7", 3'd7, 32'h55555555, 32'd1, 32'h66666666, 32'h77777777,
                   0, 32'h66666666, 32'h77777777);
        vt[9] = mk("nop0", 3'd0, 32'h55555555, 32'd1, 32'h66666666, 32'h77777777,
                   0, 32'h66666666, 32'h77777777);

        bus.startE = 1'b0; bus.md_opE = 3'd0; bus.srcA = 32'd0; bus.srcB = 32'd0;
        bus.flushE = 1'b0; bus.cancelM = 1'b0; bus.md_useD = 1'b0;
        do_reset();

        // Vector table; preload right after reset also exercises the first post-reset edge.
        foreach (vt[i]) begin
            preload(vt[i].pre_hi, vt[i].pre_lo);
            cycle(1'b1, vt[i].op, vt[i].a, vt[i].b, 1'b0, 1'b0, 1'b0, bs, ss);
            run_until_idle(n);
            chk({vt[i].name, " busy cycles"}, 64'(n), 64'(vt[i].cyc));
            chk({vt[i].name, " hi"}, bus.hi, vt[i].exp_hi);
            chk({vt[i].name, " lo"}, bus.lo, vt[i].exp_lo);
        end

        // Cancel in the first busy cycle drops the result.
        preload(32'hCAFE0001, 32'hCAFE0002);
        cycle(1'b1, 3'd1, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0, bs, ss);
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, bs, ss);
        chk("cancel busy before", bs, 64'd1);
        idle(bs);
        chk("cancel busy after", bs, 64'd0);
        idle(bs);
        chk("cancel hi", bus.hi, 64'hCAFE0001);
        chk("cancel lo", bus.lo, 64'hCAFE0002);

        // Cancel in the third busy cycle is ignored.
        cycle(1'b1, 3'd1, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0, bs, ss);
        idle(bs);
        idle(bs);
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, bs, ss);
        run_until_idle(n2);
        chk("late cancel cycles", 64'(3 + n2), 64'd5);
        chk("late cancel lo", bus.lo, 64'd42);
        chk("late cancel hi", bus.hi, 64'd0);

        // Flushed start never goes busy.
        preload(32'hF00D0001, 32'hF00D0002);
        cycle(1'b1, 3'd1, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0, bs, ss);
        idle(bs);
        chk("flush busy", bs, 64'd0);
        chk("flush lo", bus.lo, 64'hF00D0002);

        // stallD across a mult with md_useD held; an mthi while busy is ignored.
        cycle(1'b1, 3'd1, 32'h10, 32'h10, 1'b0, 1'b0, 1'b1, bs, ss);
        chk("stall start cycle", ss, 64'd1);
        for (int k = 0; k < 5; k++) begin
            cycle(k == 1, (k == 1) ? 3'd5 : 3'd0, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 1'b1,
                  bs, ss);
            chk("stall busy cycle", ss, 64'd1);
            chk("busy during mult", bs, 64'd1);
        end
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, bs, ss);
        chk("stall after", ss, 64'd0);
        chk("busy after", bs, 64'd0);
        chk("ignored mthi hi", bus.hi, 64'd0);
        chk("mult 16x16 lo", bus.lo, 64'h100);

        // Reset in the middle of a long operation.
        preload(32'h1111, 32'h2222);
        cycle(1'b1, DIV_ON ? 3'd3 : 3'd1, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 1'b0, bs, ss);
        for (int k = 0; k < 3; k++) idle(bs);
        chk("busy before reset", bs, 64'd1);
        do_reset();
        for (int k = 0; k < 12; k++) idle(bs);
        chk("post-reset busy", bs, 64'd0);
        chk("post-reset hi", bus.hi, 64'd0);
        chk("post-reset lo", bus.lo, 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                      ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                      1'($urandom_range(0, 1)), bs, ss);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
